// File: rtl/directory_access_pipe.sv
// Two-stage directory access pipeline: S0 reads the addressed set, S1 presents it to the
// combinational select stage, writes the returned next state back and registers the response.
module directory_access_pipe #(
    parameter int CL_SIZE  = 4,
    parameter int TAG_SIZE = 18,
    parameter int SET_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [TAG_SIZE+SET_BITS-1:0] req_addr,
    input  logic [2:0]            req_op,
    input  logic [1:0]            req_src,
    input  logic [1:0]            req_dest,
    input  logic                  req_alloc,
    output logic [TAG_SIZE-1:0]   sel_tag_in,
    output logic [TAG_SIZE*8-1:0] sel_tag_cur,
    output logic [CL_SIZE*8-1:0]  sel_data_cur,
    output logic [2:0]            sel_operation,
    output logic [1:0]            sel_src,
    output logic [1:0]            sel_dest,
    input  logic [TAG_SIZE*8-1:0] sel_tag_next,
    input  logic [CL_SIZE*8-1:0]  sel_data_next,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_hit,
    output logic [2:0]            resp_way,
    output logic [CL_SIZE-1:0]    resp_state,
    output logic                  resp_evict,
    output logic [TAG_SIZE-1:0]   resp_evict_tag,
    output logic [CL_SIZE-1:0]    resp_evict_state,
    output logic [1:0]            resp_src,
    output logic [1:0]            resp_dest
);
    localparam int NUM_SETS = 1 << SET_BITS;

    logic [TAG_SIZE-1:0] tag_mem   [NUM_SETS][8];
    logic [CL_SIZE-1:0]  state_mem [NUM_SETS][8];

    logic                s1_valid;
    logic [TAG_SIZE-1:0] s1_tag;
    logic [SET_BITS-1:0] s1_set;
    logic [2:0]          s1_op;
    logic [1:0]          s1_src, s1_dest;
    logic                s1_alloc;
    logic [TAG_SIZE-1:0] s1_tags   [8];
    logic [CL_SIZE-1:0]  s1_states [8];
    logic [2:0]          rr_ptr;

    logic [7:0]          way_valid, hit_vec;
    logic                s1_hit, has_free, alloc_en, evict_en, target_en;
    logic [2:0]          hit_way, free_way, target_way;
    logic [TAG_SIZE-1:0] wb_tags   [8];
    logic [CL_SIZE-1:0]  wb_states [8];

    logic                s1_adv, accept, bypass;
    logic [SET_BITS-1:0] rd_set;
    logic                unused_tag_next;

    assign unused_tag_next = ^sel_tag_next;
    assign rd_set    = req_addr[SET_BITS-1:0];
    assign s1_adv    = s1_valid & (!resp_valid | resp_ready);
    assign req_ready = !rst & (!s1_valid | s1_adv);
    assign accept    = req_valid & req_ready;
    assign bypass    = s1_adv && (s1_set == rd_set);

    assign sel_tag_in    = s1_tag;
    assign sel_operation = s1_op;
    assign sel_src       = s1_src;
    assign sel_dest      = s1_dest;

    // Target selection: highest hit, else lowest free way, else round-robin victim.
    always_comb begin
        hit_way  = '0;
        free_way = '0;
        has_free = 1'b0;
        for (int unsigned w = 0; w < 8; w++) begin
            way_valid[w] = (s1_states[w] != '0);
            hit_vec[w]   = way_valid[w] && (s1_tags[w] == s1_tag);
            if (hit_vec[w])
                hit_way = 3'(w);
            if (!way_valid[w] && !has_free) begin
                free_way = 3'(w);
                has_free = 1'b1;
            end
        end
        s1_hit    = |hit_vec;
        alloc_en  = !s1_hit && s1_alloc;
        evict_en  = alloc_en && !has_free;
        target_en = s1_hit || alloc_en;
        if (s1_hit)
            target_way = hit_way;
        else if (alloc_en)
            target_way = has_free ? free_way : rr_ptr;
        else
            target_way = '0;
    end

    // Select-stage vectors and writeback values; a non-allocating miss writes back the set unchanged.
    always_comb begin
        for (int unsigned w = 0; w < 8; w++) begin
            sel_tag_cur[w*TAG_SIZE +: TAG_SIZE] = s1_tags[w];
            sel_data_cur[w*CL_SIZE +: CL_SIZE]  = s1_states[w];
            wb_tags[w]                          = s1_tags[w];
            wb_states[w] = target_en ? sel_data_next[w*CL_SIZE +: CL_SIZE] : s1_states[w];
            if (alloc_en && (3'(w) == target_way)) begin
                sel_tag_cur[w*TAG_SIZE +: TAG_SIZE] = s1_tag;
                sel_data_cur[w*CL_SIZE +: CL_SIZE]  = '0;
                wb_tags[w]                          = s1_tag;
            end else if (!way_valid[w]) begin
                sel_tag_cur[w*TAG_SIZE +: TAG_SIZE] = ~s1_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid         <= 1'b0;
            resp_valid       <= 1'b0;
            resp_hit         <= 1'b0;
            resp_way         <= '0;
            resp_state       <= '0;
            resp_evict       <= 1'b0;
            resp_evict_tag   <= '0;
            resp_evict_state <= '0;
            resp_src         <= '0;
            resp_dest        <= '0;
            rr_ptr           <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++)
                for (int unsigned w = 0; w < 8; w++)
                    state_mem[s][w] <= '0;
        end else begin
            if (accept)
                s1_valid <= 1'b1;
            else if (s1_adv)
                s1_valid <= 1'b0;
            if (s1_adv) begin
                for (int unsigned w = 0; w < 8; w++)
                    state_mem[s1_set][w] <= wb_states[w];
                resp_valid       <= 1'b1;
                resp_hit         <= s1_hit;
                resp_way         <= target_way;
                resp_state       <= target_en ? sel_data_next[target_way*CL_SIZE +: CL_SIZE] : '0;
                resp_evict       <= evict_en;
                resp_evict_tag   <= evict_en ? s1_tags[target_way] : '0;
                resp_evict_state <= evict_en ? s1_states[target_way] : '0;
                resp_src         <= s1_src;
                resp_dest        <= s1_dest;
                if (evict_en)
                    rr_ptr <= rr_ptr + 3'd1;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // Tags are never reset; the S1 snapshot takes the in-flight writeback when sets collide.
    always_ff @(posedge clk) begin
        if (!rst && s1_adv)
            for (int unsigned w = 0; w < 8; w++)
                tag_mem[s1_set][w] <= wb_tags[w];
        if (accept) begin
            s1_tag   <= req_addr[TAG_SIZE+SET_BITS-1:SET_BITS];
            s1_set   <= rd_set;
            s1_op    <= req_op;
            s1_src   <= req_src;
            s1_dest  <= req_dest;
            s1_alloc <= req_alloc;
            for (int unsigned w = 0; w < 8; w++) begin
                s1_tags[w]   <= bypass ? wb_tags[w]   : tag_mem[rd_set][w];
                s1_states[w] <= bypass ? wb_states[w] : state_mem[rd_set][w];
            end
        end
    end

endmodule

// File: tb/tb_directory_access_pipe.sv
// Directed bench for directory_access_pipe with a stub select stage and an in-order
// response scoreboard driven by a reference model of the directory.
module tb_directory_access_pipe;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_alloc;
    logic [23:0]  req_addr;
    logic [2:0]   req_op;
    logic [1:0]   req_src, req_dest;
    logic [17:0]  sel_tag_in;
    logic [143:0] sel_tag_cur, sel_tag_next;
    logic [31:0]  sel_data_cur, sel_data_next;
    logic [2:0]   sel_operation;
    logic [1:0]   sel_src, sel_dest;
    logic         resp_valid, resp_ready, resp_hit, resp_evict;
    logic [2:0]   resp_way;
    logic [3:0]   resp_state, resp_evict_state;
    logic [17:0]  resp_evict_tag;
    logic [1:0]   resp_src, resp_dest;

    directory_access_pipe #(.CL_SIZE(4), .TAG_SIZE(18), .SET_BITS(6)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_op(req_op), .req_src(req_src), .req_dest(req_dest), .req_alloc(req_alloc),
        .sel_tag_in(sel_tag_in), .sel_tag_cur(sel_tag_cur), .sel_data_cur(sel_data_cur),
        .sel_operation(sel_operation), .sel_src(sel_src), .sel_dest(sel_dest),
        .sel_tag_next(sel_tag_next), .sel_data_next(sel_data_next),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_state(resp_state), .resp_evict(resp_evict),
        .resp_evict_tag(resp_evict_tag), .resp_evict_state(resp_evict_state),
        .resp_src(resp_src), .resp_dest(resp_dest)
    );

    always #5 clk = ~clk;

    // Stub select stage: highest-index tag match gets state 1, other ways pass through.
    logic       stub_hit;
    logic [2:0] stub_way;
    always_comb begin
        sel_tag_next  = '0;
        sel_data_next = sel_data_cur;
        stub_hit      = 1'b0;
        stub_way      = '0;
        for (int w = 0; w < 8; w++)
            if (sel_tag_cur[w*18 +: 18] == sel_tag_in) begin
                stub_hit = 1'b1;
                stub_way = w[2:0];
            end
        if (stub_hit)
            sel_data_next[stub_way*4 +: 4] = 4'h1;
    end

    int checks = 0;
    int errors = 0;
    int last_wait;
    int resp_n = 0;

    typedef logic [34:0] resp_t;
    resp_t exp_q[$];

    logic [17:0] m_tag   [64][8];
    logic [3:0]  m_state [64][8];
    logic [2:0]  m_rr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 8; w++) begin
                m_state[s][w] = '0;
                m_tag[s][w]   = '0;
            end
        m_rr = '0;
    endtask

    function automatic resp_t model_req(input logic [17:0] tag, input logic [5:0] set,
                                        input logic alloc, input logic [1:0] src, input logic [1:0] dest);
        logic        hit = 1'b0, ev = 1'b0, found = 1'b0;
        logic [2:0]  way = '0;
        logic [3:0]  st = '0, est = '0;
        logic [17:0] etag = '0;
        for (int w = 0; w < 8; w++)
            if (m_state[set][w] != 0 && m_tag[set][w] == tag) begin
                hit = 1'b1;
                way = w[2:0];
            end
        if (hit) begin
            m_state[set][way] = 4'h1;
            st = 4'h1;
        end else if (alloc) begin
            for (int w = 0; w < 8; w++)
                if (!found && m_state[set][w] == 0) begin
                    found = 1'b1;
                    way = w[2:0];
                end
            if (!found) begin
                way  = m_rr;
                ev   = 1'b1;
                etag = m_tag[set][way];
                est  = m_state[set][way];
                m_rr = m_rr + 3'd1;
            end
            m_tag[set][way]   = tag;
            m_state[set][way] = 4'h1;
            st = 4'h1;
        end
        return {hit, way, st, ev, etag, est, src, dest};
    endfunction

    // Leaves req_valid high on return so successive calls are back-to-back.
    task automatic issue(input logic [17:0] tag, input logic [5:0] set, input logic alloc, input logic push);
        int waited = 0;
        resp_t e;
        req_valid = 1'b1;
        req_addr  = {tag, set};
        req_alloc = alloc;
        req_op    = 3'($urandom);
        req_src   = 2'($urandom);
        req_dest  = 2'($urandom);
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        last_wait = waited;
        if (!req_ready) begin
            check("req_ready_timeout", 64'(req_ready), 64'd1);
        end else begin
            e = model_req(tag, set, alloc, req_src, req_dest);
            if (push)
                exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        idle();
        while (exp_q.size() != 0 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL resp_unexpected observed=response expected=none");
            end
            if (exp_q.size() > 0)
                check($sformatf("resp%0d", resp_n),
                      64'({resp_hit, resp_way, resp_state, resp_evict, resp_evict_tag,
                           resp_evict_state, resp_src, resp_dest}),
                      64'(exp_q.pop_front()));
            resp_n++;
        end
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; req_alloc = 1'b0;
        req_addr = '0; req_op = '0; req_src = '0; req_dest = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_fields", 64'({resp_hit, resp_way, resp_state, resp_evict,
                                      resp_evict_tag, resp_evict_state}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First allocation in set 5, with latency check.
        issue(18'h00ABC, 6'd5, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        check("lat_s1_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("lat_resp_valid", 64'(resp_valid), 64'd1);
        drain();

        issue(18'h00ABC, 6'd5, 1'b1, 1'b1);
        drain();

        // Same-set back-to-back allocations.
        issue(18'h00001, 6'd5, 1'b1, 1'b1);
        issue(18'h00002, 6'd5, 1'b1, 1'b1);
        check("b2b_no_bubble", 64'(last_wait), 64'd0);
        issue(18'h00001, 6'd5, 1'b1, 1'b1);
        check("b2b_hit_no_bubble", 64'(last_wait), 64'd0);
        drain();

        // Non-allocating misses leave the set unchanged.
        issue(18'h00005, 6'd20, 1'b0, 1'b1);
        issue(18'h00005, 6'd20, 1'b0, 1'b1);
        issue(18'h00005, 6'd20, 1'b1, 1'b1);
        drain();

        // Fill set 7, then two evictions through the round-robin pointer.
        for (int i = 0; i < 8; i++)
            issue(18'h10 + 18'(i), 6'd7, 1'b1, 1'b1);
        issue(18'h00020, 6'd7, 1'b1, 1'b1);
        issue(18'h00021, 6'd7, 1'b1, 1'b1);
        issue(18'h00017, 6'd7, 1'b1, 1'b1);
        drain();

        // Backpressure: response held, S1 full, request input blocked.
        resp_ready = 1'b0;
        issue(18'h00030, 6'd9, 1'b1, 1'b1);
        issue(18'h00031, 6'd10, 1'b1, 1'b1);
        req_addr = {18'h00032, 6'd11};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_req_ready%0d", i), 64'(req_ready), 64'd0);
            check($sformatf("stall_resp_valid%0d", i), 64'(resp_valid), 64'd1);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        issue(18'h00032, 6'd11, 1'b1, 1'b1);
        issue(18'h00030, 6'd9, 1'b1, 1'b1);
        issue(18'h00031, 6'd10, 1'b1, 1'b1);
        drain();

        // Reset with S1 occupied: the request is dropped silently.
        issue(18'h00099, 6'd5, 1'b1, 1'b0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("midrst_resp_valid2", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        issue(18'h00099, 6'd5, 1'b1, 1'b1);
        issue(18'h00ABC, 6'd5, 1'b1, 1'b1);
        issue(18'h00099, 6'd5, 1'b1, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
